fm_tone_seq_tx: RTL
===================

FM_TONE_SEQ_TX -- requirements
Module: fm_tone_seq_tx

Interface
REQ-001 SHALL have parameter ACC_W, default 24, carrier phase-accumulator width.
REQ-002 SHALL have parameter TONE_W, default 16, tone phase-accumulator and tone-FCW width.
REQ-003 SHALL have parameter TONE_CH, default 4, number of tone slots, range 1..8.
REQ-004 SHALL have parameter DWELL_W, default 12, dwell/gap counter width.
REQ-005 SHALL have parameter TICK_DIV, default 1024, clocks per dwell tick, >=1.
REQ-006 SHALL have ports, clock and reset first: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-007 SHALL have ports: ena in 1 clock enable; cfg_we in 1 write strobe; cfg_addr in 5 register address; cfg_data in ACC_W write data.
REQ-008 SHALL have ports: start in 1 run request; stop in 1 abort request; loop in 1 repeat mode.
REQ-009 SHALL have ports: rf_out out 1 carrier MSB; tone_out out 1 tone MSB; busy out 1 run active; slot_idx out 3 current slot.
REQ-010 SHALL have ports: done out 1 one-cycle end pulse; cfg_err out 1 one-cycle rejected-write pulse.

Function
REQ-011 SHALL map registers: 0 carrier FCW (ACC_W); 1 deviation (ACC_W); 2 gap length (DWELL_W); 8+i tone FCW slot i (TONE_W); 16+i dwell slot i (DWELL_W); writes truncate to LSBs; unmapped addresses ignored silently.
REQ-012 SHALL implement states IDLE, KEY, GAP, DONE.
REQ-013 SHALL, in IDLE with start=1, stop=0, enter KEY for slot 0 next cycle; busy high from that cycle.
REQ-014 SHALL hold KEY exactly dwell[i]*TICK_DIV cycles; prescaler and dwell counter reload on every state entry.
REQ-015 SHALL skip a slot with dwell 0 in one cycle, rf_out low that cycle.
REQ-016 SHALL, after KEY, hold GAP gap*TICK_DIV cycles (gap 0: go straight to next slot); rf_out and tone_out low in GAP.
REQ-017 SHALL, after slot TONE_CH-1, go to slot 0 if loop=1, else DONE for one cycle (done=1, busy=1), then IDLE.
REQ-018 SHALL, in KEY, advance tone accumulator by tone FCW[i] and carrier accumulator by carrier+dev when tone MSB=1, carrier-dev when 0, modulo 2^ACC_W.
REQ-019 SHALL clear both accumulators on entry to KEY from IDLE; they hold through GAP.
REQ-020 SHALL drive rf_out/tone_out as accumulator MSBs in KEY, 0 elsewhere.
REQ-021 SHALL, on stop=1 while busy, enter IDLE next cycle without done; stop and start together: stop wins.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL drop cfg_we while busy and pulse cfg_err next cycle; registers unchanged.
REQ-024 SHALL freeze all state, counters, accumulators when ena=0; pulses not reissued.
REQ-025 SHALL drive slot_idx as the current slot in KEY/GAP, 0 in IDLE.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear state to IDLE, all registers, counters, accumulators to 0, all outputs to 0.
REQ-027 SHALL resume only on a fresh start after rst_n deasserts mid-run.

Structure
REQ-028 SHALL place state enum, register address constants and parameter defaults in package fm_tone_pkg.
REQ-029 SHALL use sub-module fm_nco (parametrised-width phase accumulator with enable, clear, increment), instantiated twice.

Verification
REQ-030 SHALL check reset: rst_n low mid-KEY -> all outputs 0 same cycle, busy stays 0 after release until start.
REQ-031 SHALL check single-shot, TICK_DIV=4, dwell {2,1,0,3}, gap 1: KEY 8,4,skip(1),12 cycles, GAP 4 cycles between, done one cycle, busy falls.
REQ-032 SHALL check FM: carrier 0x200000, dev 0x100000, tone FCW 0x8000 -> carrier increments alternate 0x300000/0x100000 each cycle.
REQ-033 SHALL check loop=1, 2 slots: slot_idx sequence 0,1,0,1; stop in KEY -> IDLE next cycle, no done.
REQ-034 SHALL check config write to address 0 while busy -> cfg_err pulses one cycle, next run uses old carrier value.
REQ-035 SHALL check ena=0 for 10 cycles mid-KEY -> KEY length extended by exactly 10 cycles.

Source files
------------

// File: rtl/fm_tone_pkg.sv
// Shared types and constants for the FM tone-sequence transmitter.
// Holds the state encoding, register map and parameter defaults.
package fm_tone_pkg;

  localparam int unsigned DefAccW    = 24;
  localparam int unsigned DefToneW   = 16;
  localparam int unsigned DefToneCh  = 4;
  localparam int unsigned DefDwellW  = 12;
  localparam int unsigned DefTickDiv = 1024;

  localparam logic [4:0] AddrCarrier   = 5'd0;
  localparam logic [4:0] AddrDev       = 5'd1;
  localparam logic [4:0] AddrGap       = 5'd2;
  localparam logic [4:0] AddrToneBase  = 5'd8;
  localparam logic [4:0] AddrDwellBase = 5'd16;

  typedef enum logic [1:0] {
    StIdle,
    StKey,
    StGap,
    StDone
  } fm_state_e;

endpackage

// File: rtl/fm_nco.sv
// Phase accumulator with synchronous clear (priority over enable).
// Only the MSB leaves the block; it is the square-wave output of the NCO.
module fm_nco #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] inc_i,
  output logic         msb_o
);

  logic [W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = phase_q + inc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign msb_o = phase_q[W-1];

endmodule

// File: rtl/fm_tone_seq_tx.sv
// Tone-sequence FM transmitter: steps through tone slots, keying a carrier NCO
// that is frequency-shifted by the MSB of a per-slot tone NCO.
module fm_tone_seq_tx
  import fm_tone_pkg::*;
#(
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned TONE_W   = DefToneW,
  parameter int unsigned TONE_CH  = DefToneCh,
  parameter int unsigned DWELL_W  = DefDwellW,
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_addr,
  input  logic [ACC_W-1:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             rf_out,
  output logic             tone_out,
  output logic             busy,
  output logic [2:0]       slot_idx,
  output logic             done,
  output logic             cfg_err
);

  localparam int unsigned SlotW = (TONE_CH > 1) ? $clog2(TONE_CH) : 1;
  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  logic [ACC_W-1:0]   car_fcw_q, dev_q;
  logic [DWELL_W-1:0] gap_q;
  logic [TONE_W-1:0]  tone_fcw_q [TONE_CH];
  logic [DWELL_W-1:0] dwell_q    [TONE_CH];
  logic               cfg_err_q;

  fm_state_e          state_q, state_d;
  logic [2:0]         slot_q, slot_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [SlotW-1:0]   cur;
  logic [DWELL_W-1:0] dwell_cur, seg_len;
  logic               key_on, tick_last, seg_end, last_slot, adv;
  logic               nco_en, nco_clr, tone_msb, car_msb;
  logic [ACC_W-1:0]   car_inc;

  assign busy = (state_q != StIdle);

  // Config writes are only accepted while idle; a write during a run is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_fcw_q <= '0;
      dev_q     <= '0;
      gap_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < TONE_CH; i++) begin
        tone_fcw_q[i] <= '0;
        dwell_q[i]    <= '0;
      end
    end else begin
      cfg_err_q <= cfg_we && busy;
      if (cfg_we && !busy) begin
        if (cfg_addr == AddrCarrier) car_fcw_q <= cfg_data;
        if (cfg_addr == AddrDev)     dev_q     <= cfg_data;
        if (cfg_addr == AddrGap)     gap_q     <= cfg_data[DWELL_W-1:0];
        for (int i = 0; i < TONE_CH; i++) begin
          if (cfg_addr == AddrToneBase + 5'(i))  tone_fcw_q[i] <= cfg_data[TONE_W-1:0];
          if (cfg_addr == AddrDwellBase + 5'(i)) dwell_q[i]    <= cfg_data[DWELL_W-1:0];
        end
      end
    end
  end

  assign cur       = slot_q[SlotW-1:0];
  assign dwell_cur = dwell_q[cur];
  assign key_on    = (state_q == StKey) && (dwell_cur != '0);
  assign seg_len   = (state_q == StGap) ? gap_q : dwell_cur;
  assign tick_last = (pre_q == PreLast);
  assign seg_end   = tick_last && ((cnt_q + 1'b1) == seg_len);
  assign last_slot = (slot_q == 3'(TONE_CH - 1));

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    nco_en  = 1'b0;
    nco_clr = 1'b0;
    adv     = 1'b0;
    if (ena) begin
      if (tick_last) begin
        pre_d = '0;
        cnt_d = cnt_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          pre_d = '0;
          cnt_d = '0;
          if (start && !stop) begin
            state_d = StKey;
            slot_d  = 3'd0;
            nco_clr = 1'b1;
          end
        end
        StKey: begin
          nco_en = key_on;
          if (!key_on) begin
            adv = 1'b1;  // zero-dwell slot costs exactly one cycle, no gap
          end else if (seg_end) begin
            if (gap_q == '0) begin
              adv = 1'b1;
            end else begin
              state_d = StGap;
              pre_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        StGap: begin
          if (seg_end) adv = 1'b1;
        end
        StDone: begin
          state_d = StIdle;
          slot_d  = 3'd0;
        end
        default: state_d = StIdle;
      endcase
      if (adv) begin
        pre_d = '0;
        cnt_d = '0;
        if (!last_slot) begin
          state_d = StKey;
          slot_d  = slot_q + 3'd1;
        end else if (loop) begin
          state_d = StKey;
          slot_d  = 3'd0;
        end else begin
          state_d = StDone;
        end
      end
      if (stop && busy) begin
        state_d = StIdle;
        slot_d  = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      slot_q  <= 3'd0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  assign car_inc = tone_msb ? (car_fcw_q + dev_q) : (car_fcw_q - dev_q);

  fm_nco #(
    .W(TONE_W)
  ) u_tone_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (nco_en),
    .clr_i (nco_clr),
    .inc_i (tone_fcw_q[cur]),
    .msb_o (tone_msb)
  );

  fm_nco #(
    .W(ACC_W)
  ) u_car_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (nco_en),
    .clr_i (nco_clr),
    .inc_i (car_inc),
    .msb_o (car_msb)
  );

  assign rf_out   = key_on && car_msb;
  assign tone_out = key_on && tone_msb;
  assign done     = (state_q == StDone) && ena;
  assign cfg_err  = cfg_err_q;
  assign slot_idx = ((state_q == StKey) || (state_q == StGap)) ? slot_q : 3'd0;

endmodule
